// File: rtl/dip_scan_controller.sv
// Serial DIP/switch chain sequencer: latches the chain, clocks out FRAME_BITS bits, publishes 16+5 bit words.
// Latency: i_ScanReq in IDLE -> o_Valid 2+2*CLK_DIV*(FRAME_BITS+1) cycles later; frame period adds 1+GAP_CYCLES.
// No backpressure: o_Valid is a one-cycle strobe; i_ScanReq while o_Busy=1 is dropped. Macro: DIP_SCAN_DEBOUNCE_EN.
module dip_scan_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 24,
  parameter int GAP_CYCLES = 8
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_Enable,
  input  logic        i_ScanReq,
  input  logic        i_Data,
  output logic        o_SCLK,
  output logic        o_Latch_n,
  output logic [15:0] o_DIP16,
  output logic [4:0]  o_Switch5,
  output logic        o_Valid,
  output logic        o_Changed,
  output logic        o_Busy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [5:0]       BIT_LAST   = 6'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_UPDATE,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       bit_q;
  // Raw frame packed as {DIP16, Switch5}: DIP bit j at [5+j], switch bit j at [j].
  logic [20:0]      raw_q;
  logic             sclk_q;
  logic             latch_n_q;
  logic [15:0]      dip_q;
  logic [4:0]       sw_q;
  logic             valid_q;
  logic             changed_q;
  logic             busy_q;

  logic [4:0]       raw_idx_d;
  logic             raw_we_d;
  logic             accept_d;

  // Map the arrival index of the current bit onto its slot in the raw frame.
  always_comb begin
    raw_idx_d = '0;
    raw_we_d  = 1'b0;
    if (bit_q < 6'd16) begin
      // First byte off the chain belongs in DIP[15:8], second in DIP[7:0].
      raw_idx_d = 5'd5 + {1'b0, bit_q[3:0] ^ 4'h8};
      raw_we_d  = 1'b1;
    end else if (bit_q < 6'd21) begin
      raw_idx_d = bit_q[4:0] - 5'd16;
      raw_we_d  = 1'b1;
    end
  end

`ifdef DIP_SCAN_DEBOUNCE_EN
  logic [20:0] cand_q;

  assign accept_d = (raw_q == cand_q);

  // Remember every raw frame so the next one can be compared against it.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cand_q <= '0;
    end else if (state_q == S_UPDATE) begin
      cand_q <= raw_q;
    end
  end
`else
  assign accept_d = 1'b1;
`endif

  // Frame sequencer; all chain-facing and published outputs are registered here.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      raw_q     <= '0;
      sclk_q    <= 1'b0;
      latch_n_q <= 1'b1;
      dip_q     <= '0;
      sw_q      <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Enable || i_ScanReq) begin
            state_q   <= S_LATCH;
            latch_n_q <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
          end
        end
        S_LATCH: begin
          if (cnt_q == LATCH_LAST) begin
            state_q   <= S_SHIFT;
            latch_n_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              // Last low-phase cycle: data is stable before the chain shifts.
              if (raw_we_d) begin
                raw_q[raw_idx_d] <= i_Data;
              end
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                state_q <= S_UPDATE;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_UPDATE: begin
          if (accept_d) begin
            dip_q     <= raw_q[20:5];
            sw_q      <= raw_q[4:0];
            valid_q   <= 1'b1;
            changed_q <= (raw_q != {dip_q, sw_q});
          end
          state_q <= S_GAP;
          cnt_q   <= '0;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (i_Enable) begin
              state_q   <= S_LATCH;
              latch_n_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          sclk_q    <= 1'b0;
          latch_n_q <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign o_SCLK    = sclk_q;
  assign o_Latch_n = latch_n_q;
  assign o_DIP16   = dip_q;
  assign o_Switch5 = sw_q;
  assign o_Valid   = valid_q;
  assign o_Changed = changed_q;
  assign o_Busy    = busy_q;

endmodule
